// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM states
// and the nibble-count derivation used to size the iteration counter.
package nibble_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of nibble cycles needed for a WIDTH-bit operand.
  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_add.sv
// Combinational 4-bit adder slice. Besides the carry out it exposes the carry
// into bit 3, so the caller can form signed overflow on the top nibble.
module nibble_add
  import nibble_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s4,
  output logic                co,
  output logic                c3
);

  logic [NIBBLE_W:0]   full_s;
  logic [NIBBLE_W-1:0] low_s;

  // Full 5-bit sum gives the nibble result and its carry out.
  assign full_s = {1'b0, a4} + {1'b0, b4} + {4'b0000, ci};
  // Sum of the low three bits only: its MSB is the carry into bit 3.
  assign low_s  = {1'b0, a4[2:0]} + {1'b0, b4[2:0]} + {3'b000, ci};

  assign s4 = full_s[NIBBLE_W-1:0];
  assign co = full_s[NIBBLE_W];
  assign c3 = low_s[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder, one nibble per clock, LSB nibble first.
// Optional feature macro: NIBBLE_SERIAL_ADDER_SUB_EN adds a 'sub' input that
// turns the operation into a-b (B inverted, carry-in forced to 1).
module nibble_serial_adder
  import nibble_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NIB = nib_count(WIDTH);
  localparam int CW  = (NIB > 2) ? $clog2(NIB) : 1;

  logic             sub_s;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, vf_q, vf_d;
  logic             c_out_q, c_out_d, ovf_q, ovf_d;
  logic             done_q, done_d, ready_q, ready_d;
  logic [NIBBLE_W-1:0] s4_s;
  logic             co_s, c3_s;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  assign sub_s = sub;
`else
  assign sub_s = 1'b0;
`endif

  // Single adder slice, reused on every RUN cycle on the low working nibbles.
  nibble_add u_nibble_add (
    .a4 (a_q[NIBBLE_W-1:0]),
    .b4 (b_q[NIBBLE_W-1:0]),
    .ci (carry_q),
    .s4 (s4_s),
    .co (co_s),
    .c3 (c3_s)
  );

  // Next-state and datapath logic; result outputs only change on leaving DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    vf_d    = vf_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub_s ? ~b : b;
          carry_d = sub_s ? 1'b1 : c_in;
          res_d   = {WIDTH{1'b0}};
          vf_d    = 1'b0;
          cnt_d   = {CW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_d   = {s4_s, res_q[WIDTH-1:NIBBLE_W]};
        a_d     = a_q >> NIBBLE_W;
        b_d     = b_q >> NIBBLE_W;
        carry_d = co_s;
        // Only the value from the final (top) nibble survives to DONE.
        vf_d    = c3_s ^ co_s;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NIB - 1)) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        sum_d   = res_q;
        c_out_d = carry_q;
        ovf_d   = vf_q;
        done_d  = 1'b1;
        if (start) begin
          a_d     = a;
          b_d     = sub_s ? ~b : b;
          carry_d = sub_s ? 1'b1 : c_in;
          res_d   = {WIDTH{1'b0}};
          vf_d    = 1'b0;
          cnt_d   = {CW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d != RUN);
  end

  // State, working registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      carry_q <= 1'b0;
      vf_q    <= 1'b0;
      sum_q   <= {WIDTH{1'b0}};
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      vf_q    <= vf_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed cases plus random
// traffic compared against an arithmetic reference model with a result queue.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             c_in;
  logic             sub;
  logic             ready, done, c_out, overflow;
  logic [WIDTH-1:0] sum;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .sub      (sub),
`endif
    .start    (start),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .ready    (ready),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
    int               due;
  } exp_t;

  exp_t             q[$];
  int               total = 0;
  int               bad = 0;
  int               cyc = 0;
  int               last_acc = -100;
  logic [WIDTH-1:0] last_sum = '0;
  logic             last_co = 1'b0;
  logic             last_ov = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain wide arithmetic, signed overflow from operand/result signs.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic ci, input logic sb);
    exp_t             e;
    logic [WIDTH-1:0] yy;
    logic [WIDTH:0]   full;
    logic             cc;
    yy   = sb ? ~y : y;
    cc   = sb ? 1'b1 : ci;
    full = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, cc};
    e.s  = full[WIDTH-1:0];
    e.co = full[WIDTH];
    e.ov = (x[WIDTH-1] == yy[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
    e.due = 0;
    return e;
  endfunction

  // Advance one clock and compare all outputs against the model.
  task automatic step();
    bit   acc;
    exp_t e;
    acc = (rst_n === 1'b1) && (start === 1'b1) && (cyc >= last_acc + NIB);
    e = model(a, b, c_in, sub);
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      e.due = cyc + NIB + 1;
      q.push_back(e);
      last_acc = cyc;
    end
    check_val("ready", ready, (cyc >= last_acc + NIB));
    if (q.size() > 0 && q[0].due == cyc) begin
      check_val("done_pulse", done, 1);
      check_val("sum", sum, q[0].s);
      check_val("c_out", c_out, q[0].co);
      check_val("overflow", overflow, q[0].ov);
      last_sum = q[0].s;
      last_co  = q[0].co;
      last_ov  = q[0].ov;
      void'(q.pop_front());
    end else begin
      check_val("done_idle", done, 0);
      check_val("sum_hold", sum, last_sum);
      check_val("c_out_hold", c_out, last_co);
      check_val("ovf_hold", overflow, last_ov);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * NIB && q.size() > 0; i++) step();
    check_val("drain_timeout", q.size(), 0);
  endtask

  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
    a = x; b = y; c_in = ci; start = 1'b1;
    step();
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'($urandom);
  endtask

  typedef struct {
    logic [WIDTH-1:0] a, b;
    logic             ci;
    logic [WIDTH-1:0] s;
    logic             co, ov;
  } dir_t;

  dir_t dirs[5];
  int   accepted;

  initial begin
    dirs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    dirs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    dirs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    dirs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    dirs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ready", ready, 1);
    check_val("rst_done", done, 0);
    check_val("rst_sum", sum, 0);
    check_val("rst_c_out", c_out, 0);
    check_val("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    step();

    // Directed arithmetic cases with spelled-out expectations.
    for (int i = 0; i < 5; i++) begin
      issue(dirs[i].a, dirs[i].b, dirs[i].ci);
      drain();
      check_val("dir_sum", sum, dirs[i].s);
      check_val("dir_c_out", c_out, dirs[i].co);
      check_val("dir_ovf", overflow, dirs[i].ov);
    end

    // Start pulse during RUN must be ignored.
    issue(16'h0001, 16'h0001, 1'b0);
    a = 16'h00FF; b = 16'h0001; start = 1'b1;
    step();
    start = 1'b0;
    drain();
    repeat (3) step();
    check_val("busy_sum", sum, 16'h0002);

    // Reset in the middle of an operation.
    issue(16'h1111, 16'h2222, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_sum", sum, 0);
    check_val("mid_rst_done", done, 0);
    check_val("mid_rst_ready", ready, 1);
    check_val("mid_rst_c_out", c_out, 0);
    check_val("mid_rst_ovf", overflow, 0);
    q.delete();
    last_sum = '0; last_co = 1'b0; last_ov = 1'b0; last_acc = -100;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (NIB + 2) step();
    issue(16'h0010, 16'h0020, 1'b0);
    drain();
    check_val("post_rst_sum", sum, 16'h0030);

    // Back-to-back: start held high, fresh operands after each acceptance.
    accepted = 0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'($urandom);
    start = 1'b1;
    for (int i = 0; i < 6 * (NIB + 1) && accepted < 4; i++) begin
      step();
      if (last_acc == cyc) begin
        accepted++;
        a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'($urandom);
        if (accepted == 4) start = 1'b0;
      end
    end
    start = 1'b0;
    check_val("b2b_accepts", accepted, 4);
    drain();

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    issue(16'h0005, 16'h0007, 1'b0);
    sub = 1'b0;
    drain();
    check_val("sub_sum", sum, 16'hFFFE);
    check_val("sub_c_out", c_out, 0);
`endif

    // Random traffic: random start pulses, operands change every cycle.
    for (int i = 0; i < 400; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'($urandom);
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      sub = 1'($urandom);
`endif
      start = ($urandom_range(0, 3) == 0);
      step();
    end
    start = 1'b0;
    sub = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
